// File: rtl/blockram_dual_port_be.sv
// True dual-port block RAM with per-byte write enables, selectable same-port write mode
// and a 1- or 2-cycle read latency with a valid flag travelling alongside the data.
module blockram_dual_port_be #(
  parameter int unsigned RAM_WIDTH    = 16,
  parameter int unsigned RAM_DEPTH    = 1024,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       WRITE_MODE   = "READ_FIRST",
  localparam int unsigned NUM_BYTES   = RAM_WIDTH / BYTE_WIDTH,
  localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en_a,
  input  logic [NUM_BYTES-1:0] i_we_a,
  input  logic [ADDR_W-1:0]    i_addr_a,
  input  logic [RAM_WIDTH-1:0] i_din_a,
  output logic [RAM_WIDTH-1:0] o_dout_a,
  output logic                 o_valid_a,
  input  logic                 i_en_b,
  input  logic [NUM_BYTES-1:0] i_we_b,
  input  logic [ADDR_W-1:0]    i_addr_b,
  input  logic [RAM_WIDTH-1:0] i_din_b,
  output logic [RAM_WIDTH-1:0] o_dout_b,
  output logic                 o_valid_b
);

  localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("blockram_dual_port_be: READ_LATENCY must be 1 or 2");
  end
  if (WRITE_MODE != "READ_FIRST" && !MODE_WF && !MODE_NC) begin : g_bad_mode
    $error("blockram_dual_port_be: unknown WRITE_MODE");
  end
  if (NUM_BYTES * BYTE_WIDTH != RAM_WIDTH) begin : g_bad_width
    $error("blockram_dual_port_be: RAM_WIDTH must be a multiple of BYTE_WIDTH");
  end

  function automatic logic [RAM_WIDTH-1:0] merge_bytes(
    input logic [RAM_WIDTH-1:0] old_word,
    input logic [RAM_WIDTH-1:0] new_word,
    input logic [NUM_BYTES-1:0] be
  );
    logic [RAM_WIDTH-1:0] m;
    m = old_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (be[b]) m[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return m;
  endfunction

  (* ram_style = "block" *) logic [RAM_WIDTH-1:0] r_ram [RAM_DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic                 w_en   [2];
  logic [NUM_BYTES-1:0] w_we   [2];
  logic [ADDR_W-1:0]    w_addr [2];
  logic [RAM_WIDTH-1:0] w_din  [2];
  logic                 w_inr  [2];
  logic                 w_wr   [2];
  logic [RAM_WIDTH-1:0] w_dout [2];
  logic                 w_vld  [2];

  assign w_en[0]   = i_en_a;
  assign w_we[0]   = i_we_a;
  assign w_addr[0] = i_addr_a;
  assign w_din[0]  = i_din_a;
  assign w_en[1]   = i_en_b;
  assign w_we[1]   = i_we_b;
  assign w_addr[1] = i_addr_b;
  assign w_din[1]  = i_din_b;

  assign o_dout_a  = w_dout[0];
  assign o_valid_a = w_vld[0];
  assign o_dout_b  = w_dout[1];
  assign o_valid_b = w_vld[1];

  // Port B is applied first so port A's bytes win a write/write collision.
  always_ff @(posedge i_clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (w_wr[p]) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (w_we[p][b])
            r_ram[w_addr[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= w_din[p][b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                 w_rd;
    logic                 w_wrq;
    logic                 w_v1;
    logic [RAM_WIDTH-1:0] w_old;
    logic [RAM_WIDTH-1:0] w_d1;
    logic                 r_vld_p1;
    logic [RAM_WIDTH-1:0] r_data_p1;

    if (RAM_DEPTH == (2 ** ADDR_W)) begin : g_full
      assign w_inr[p] = 1'b1;
    end else begin : g_partial
      assign w_inr[p] = (32'(w_addr[p]) < RAM_DEPTH);
    end

    assign w_rd   = w_en[p] && (w_we[p] == '0);
    assign w_wrq  = w_en[p] && (w_we[p] != '0);
    assign w_wr[p] = !i_rst && w_wrq && w_inr[p];
    assign w_old  = w_inr[p] ? r_ram[w_addr[p]] : '0;
    assign w_v1   = !i_rst && (w_rd || (w_wrq && !MODE_NC));
    assign w_d1   = (w_wrq && MODE_WF) ? merge_bytes(w_old, w_din[p], w_we[p]) : w_old;

    // Stage 1: array output register
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld_p1  <= 1'b0;
        r_data_p1 <= '0;
      end else begin
        r_vld_p1 <= w_v1;
        if (w_v1) r_data_p1 <= w_d1;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic                 r_vld_p2;
      logic [RAM_WIDTH-1:0] r_data_p2;

      // Stage 2: optional output pipeline register
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_vld_p2  <= 1'b0;
          r_data_p2 <= '0;
        end else begin
          r_vld_p2 <= r_vld_p1;
          if (r_vld_p1) r_data_p2 <= r_data_p1;
        end
      end

      assign w_dout[p] = r_data_p2;
      assign w_vld[p]  = r_vld_p2;
    end else begin : g_lat1
      assign w_dout[p] = r_data_p1;
      assign w_vld[p]  = r_vld_p1;
    end
  end

endmodule

// File: doc/blockram_dual_port_be.md
Name: blockram_dual_port_be

Overview:
- True dual-port block RAM with two independent read/write ports, A and B, on a single clock.
- Each port has per-byte write enables, a selectable write-mode policy and a configurable read latency of 1 or 2 cycles (optional output register).
- It replaces the single-port RAM wherever two masters share one buffer, for example a producer/consumer frame buffer or a coefficient store updated while being read.
- A read-valid pipeline travels alongside the data so consumers need not count latency.

Parameters:
- RAM_WIDTH, 16: data word width in bits; must be a multiple of BYTE_WIDTH.
- RAM_DEPTH, 1024: number of words; address width is $clog2(RAM_DEPTH).
- BYTE_WIDTH, 8: write-enable granularity in bits; NUM_BYTES = RAM_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1: 1 = array output register only; 2 = additional output pipeline register. Other values are an elaboration error.
- WRITE_MODE, "READ_FIRST": same-port behaviour of data_out on a write. Values are "READ_FIRST", "WRITE_FIRST" and "NO_CHANGE".

Ports:
- clk, input, 1: single clock, all logic on the rising edge.
- rst, input, 1: synchronous active-high reset.
- en_a, input, 1: port A access enable.
- we_a, input, NUM_BYTES: port A byte write enables; only sampled while en_a=1.
- addr_a, input, $clog2(RAM_DEPTH): port A word address.
- din_a, input, RAM_WIDTH: port A write data.
- dout_a, output, RAM_WIDTH: port A read data.
- valid_a, output, 1: dout_a carries the result of an access issued READ_LATENCY cycles earlier.
- en_b, we_b, addr_b, din_b, dout_b, valid_b: identical definitions for port B.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Memory initialisation: the array is initialised to all zeros at configuration. rst never clears array contents.
- Reset:
  - While rst=1, dout_a, dout_b, valid_a and valid_b are 0, and every pipeline stage is cleared on the next edge.
  - Accesses presented while rst=1 are ignored: no write, no read issued.
  - Reads in flight when rst asserts are dropped; valid does not pulse for them after rst releases.
- Access decode, per port per cycle:
  - en=0: idle.
  - en=1, we=0: read.
  - en=1, we!=0: write. Byte i of ram[addr] takes din[i*BYTE_WIDTH +: BYTE_WIDTH] for each set we[i]; other bytes are unchanged.
- Read latency:
  - READ_LATENCY=1: stage-1 data appears on dout one edge after the access; valid is high for that cycle.
  - READ_LATENCY=2: the same data is delayed one further edge.
  - Back-to-back reads give one result per cycle with no bubbles.
- Output holding: when no result completes, dout holds its last value and valid=0.
- Same-port write, by WRITE_MODE:
  - READ_FIRST: stage-1 data is the old word at addr; valid asserts.
  - WRITE_FIRST: stage-1 data is the merged new word (new bytes where we set, old bytes elsewhere); valid asserts.
  - NO_CHANGE: dout holds; valid does not assert for the write.
- Cross-port read/write collision (one port writes address X, the other reads X in the same cycle): the reader gets the old word, independent of WRITE_MODE. The write is visible from the next cycle.
- Write/write collision (both ports write address X in the same cycle):
  - Bytes enabled on both ports take port A's data.
  - Bytes enabled on one port only take that port's data.
  - Bytes enabled on neither port are unchanged.
- Address range: addresses >= RAM_DEPTH (non-power-of-2 depth) cause no write. Reads return 0 with valid asserted.
- Implementation: the array is inferred as block RAM with a ram_style="block" attribute. The byte-collision merge is muxing on the write side only and must not break BRAM inference.

Test Plan:
1. Reset and basic latency.
   - Stimulus: rst for 2 cycles; A writes 0xBEEF to 0x010 with we=2'b11; then A reads 0x010; READ_LATENCY=1.
   - Required: dout_a=0xBEEF with valid_a=1 exactly 1 edge after the read. With READ_LATENCY=2, the same result arrives 2 edges after.
2. Byte enables.
   - Stimulus: write 0x1234 to 0x020; then A writes din 0xAB00 with we=2'b10; then read.
   - Required: read returns 0xAB34.
3. Write modes.
   - Stimulus: ram[0x030]=0x1111; A writes 0x2222 to 0x030.
   - Required: READ_FIRST gives dout_a=0x1111, valid_a=1. WRITE_FIRST gives 0x2222, valid_a=1. NO_CHANGE leaves dout_a at its prior value with valid_a=0. A subsequent read gives 0x2222 in all modes.
4. Cross-port collisions.
   - Stimulus A: A writes 0x5555 to 0x040 (old 0x0000) while B reads 0x040 in the same cycle. Required: dout_b=0x0000; B's next read returns 0x5555.
   - Stimulus B: A writes 0xAAAA with we=2'b01 and B writes 0x5555 with we=2'b11, both to 0x041 in the same cycle. Required: word becomes 0x55AA.
5. Streaming reads.
   - Stimulus: B reads addresses 0..7 on consecutive cycles after preloading word i=i*3.
   - Required: 8 consecutive valid_b cycles carrying 0,3,6,...,21 in order.
6. Reset mid-operation.
   - Stimulus: READ_LATENCY=2; issue reads on cycles 0 and 1; assert rst on cycle 1 for one cycle.
   - Required: no valid pulse afterwards; dout=0; array contents intact on re-read.
